seg_scan_2dig: RTL and testbench
================================

# seg_scan_2dig

Two-digit, time-multiplexed 7-segment display driver that consumes the BCD tens/ones digit pair produced by the binary-to-decimal split stage. It latches the digit pair once per refresh frame, so a frame never mixes digits from two different inputs. It alternates the two common-anode digit enables with a blanking gap between slots to suppress ghosting, and decodes each digit to an active-low segment pattern. It is the last stage before the board pins.

## Interface
- SCAN_CNT, 50000: clock cycles each digit is lit (≥2)
- GAP_CNT, 500: clock cycles of full blanking after each digit slot (≥1)
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous active-low reset
- Ten_Data  input  4  tens digit from upstream split stage (BCD, 10–15 invalid)
- One_Data  input  4  ones digit from upstream split stage (BCD, 10–15 invalid)
- SMG_Data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- Scan_Sig  output  2  digit enables {ten,one}, active-low
- Frame_Tick  output  1  one-cycle pulse when a new digit pair is latched

## Operation
- Reset is asynchronous and active-low; the clock and reset ports are CLK and RST.
- Four-state FSM: GAP_B (reset state) → SHOW_TEN → GAP_A → SHOW_ONE → GAP_B → …
- A single slot counter `cnt` runs 0..N-1 in each state and clears on every transition. N is SCAN_CNT in SHOW states and GAP_CNT in GAP states.
- A transition occurs on the edge where cnt == N-1.
- Input capture:
  - On the GAP_B → SHOW_TEN edge, rTen/rOne ← Ten_Data/One_Data.
  - Frame_Tick = 1 for that cycle only.
  - Inputs are ignored at all other times.
- Outputs are registered and change on the same edge as the state register:
  - SHOW_TEN: Scan_Sig = 2'b01, SMG_Data = dec(rTen).
  - SHOW_ONE: Scan_Sig = 2'b10, SMG_Data = dec(rOne).
  - GAP_A / GAP_B: Scan_Sig = 2'b11, SMG_Data = 8'hFF.
- Decode dec(), dp always off:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99
  - 5→92, 6→82, 7→F8, 8→80, 9→90
  - 10–15→BF (dash, segment g only)

## Timing
- Reset values: state GAP_B, cnt 0, rTen/rOne 0, Scan_Sig 2'b11, SMG_Data 8'hFF, Frame_Tick 0.
- Frame period = 2·(SCAN_CNT+GAP_CNT) cycles.
- After reset release, the first SHOW_TEN is entered on the GAP_CNT-th rising edge, with the first Frame_Tick on that same edge.
- Input-to-display latency is at most one frame period plus one cycle.
- Input changes in any cycle other than the capture edge have no effect until the next frame.
- Scan_Sig never has both bits low. Every change between the two digit enables passes through at least GAP_CNT cycles of 2'b11.
- Reset asserted mid-slot returns all outputs to their reset values immediately (asynchronously). On release, the block restarts from GAP_B with cnt 0.
- cnt is sized to $clog2(max(SCAN_CNT,GAP_CNT)) bits and never wraps past N-1.

## Configuration
- SEG_LZB_EN defined (leading-zero blanking):
  - When rTen == 0, the SHOW_TEN slot drives Scan_Sig = 2'b11 and SMG_Data = 8'hFF.
  - Slot timing and Frame_Tick are unchanged.
  - The ones digit is never blanked.
- SEG_LZB_EN undefined: a zero tens digit displays C0 like any other digit.

## Test plan
All scenarios use SCAN_CNT = 8 and GAP_CNT = 2, giving a 20-cycle frame.
- Reset then release with Ten=4, One=2:
  - Outputs hold 11/FF for 2 cycles, then Frame_Tick pulses.
  - Scan_Sig 01 / SMG 99 for 8 cycles, then 11/FF for 2.
  - Scan_Sig 10 / SMG A4 for 8 cycles, then 11/FF for 2.
  - The pattern repeats every 20 cycles.
- Change inputs to 7/3 mid SHOW_TEN: the current frame still shows 99/A4; the next frame shows F8/B0 after the next Frame_Tick.
- Ten=12, One=15: both slots show BF.
- Ten=0, One=5: SHOW_TEN slot shows 01/C0 without SEG_LZB_EN, or 11/FF with SEG_LZB_EN. The ones slot shows 10/92 in both builds.
- Assert RST low for 1 cycle during SHOW_ONE cycle 4: outputs go to 11/FF/0 at once. On release, the sequence restarts exactly as in the first scenario.
- Run 1000 cycles with random inputs: Scan_Sig is never 00, every 01↔10 change passes through ≥2 cycles of 11, and Frame_Tick spacing is exactly 20 cycles.

Source files
------------

// File: rtl/seg_scan_2dig_if.sv
// Digit-pair input and pin-side outputs of the two-digit 7-segment scanner.
// master drives the BCD pair; slave is the scanner itself.
interface seg_scan_2dig_if;
    logic [3:0] Ten_Data;
    logic [3:0] One_Data;
    logic [7:0] SMG_Data;
    logic [1:0] Scan_Sig;
    logic       Frame_Tick;

    modport master (
        output Ten_Data,
        output One_Data,
        input  SMG_Data,
        input  Scan_Sig,
        input  Frame_Tick
    );

    modport slave (
        input  Ten_Data,
        input  One_Data,
        output SMG_Data,
        output Scan_Sig,
        output Frame_Tick
    );
endinterface

// File: rtl/seg_scan_2dig.sv
// Two-digit multiplexed common-anode 7-segment driver with blanking gaps.
// Optional leading-zero blanking of the tens digit: define SEG_LZB_EN.
module seg_scan_2dig #(
    parameter int SCAN_CNT = 50000,
    parameter int GAP_CNT  = 500
) (
    input  logic           CLK,
    input  logic           RST,
    seg_scan_2dig_if.slave bus
);

    typedef enum logic [1:0] {
        GAP_B,
        SHOW_TEN,
        GAP_A,
        SHOW_ONE
    } state_t;

    localparam int MAXN = (SCAN_CNT > GAP_CNT) ? SCAN_CNT : GAP_CNT;
    localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CNT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CNT - 1);

`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    r_ten;
    logic [3:0]    r_one;
    logic [3:0]    ten_nxt;
    logic [3:0]    one_nxt;
    logic [7:0]    smg;
    logic [7:0]    smg_nxt;
    logic [1:0]    scan;
    logic [1:0]    scan_nxt;
    logic          tick;
    logic          tick_nxt;
    logic          show;
    logic          last;

    function automatic logic [7:0] dec(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= GAP_B;
            cnt   <= '0;
            r_ten <= 4'd0;
            r_one <= 4'd0;
            smg   <= 8'hFF;
            scan  <= 2'b11;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            r_ten <= ten_nxt;
            r_one <= one_nxt;
            smg   <= smg_nxt;
            scan  <= scan_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        ten_nxt   = r_ten;
        one_nxt   = r_one;
        tick_nxt  = 1'b0;
        smg_nxt   = 8'hFF;
        scan_nxt  = 2'b11;
        show      = (state == SHOW_TEN) || (state == SHOW_ONE);
        last      = show ? (cnt == SCAN_LAST) : (cnt == GAP_LAST);

        if (last) begin
            cnt_nxt = '0;
            unique case (state)
                GAP_B: begin
                    state_nxt = SHOW_TEN;
                    ten_nxt   = bus.Ten_Data;
                    one_nxt   = bus.One_Data;
                    tick_nxt  = 1'b1;
                end
                SHOW_TEN: state_nxt = GAP_A;
                GAP_A:    state_nxt = SHOW_ONE;
                SHOW_ONE: state_nxt = GAP_B;
            endcase
        end

        // Outputs follow the upcoming state so they switch with it.
        unique case (state_nxt)
            SHOW_TEN: begin
                if (!(LZB && ten_nxt == 4'd0)) begin
                    scan_nxt = 2'b01;
                    smg_nxt  = dec(ten_nxt);
                end
            end
            SHOW_ONE: begin
                scan_nxt = 2'b10;
                smg_nxt  = dec(one_nxt);
            end
            GAP_A, GAP_B: begin
                scan_nxt = 2'b11;
                smg_nxt  = 8'hFF;
            end
        endcase
    end

    assign bus.SMG_Data   = smg;
    assign bus.Scan_Sig   = scan;
    assign bus.Frame_Tick = tick;

endmodule

// File: tb/tb_seg_scan_2dig.sv
// Directed bench for seg_scan_2dig with SCAN_CNT=8, GAP_CNT=2.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_seg_scan_2dig;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_bad;

    seg_scan_2dig_if bus ();

    seg_scan_2dig #(
        .SCAN_CNT(8),
        .GAP_CNT (2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] tbl [0:15];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        return tbl[d];
    endfunction

    // {tick, scan, smg} expected after the k-th edge since reset release.
    function automatic logic [10:0] exp_vec(input int k,
                                            input logic [3:0] t,
                                            input logic [3:0] o);
        int p;
        if (k < 2) return {1'b0, 2'b11, 8'hFF};
        p = (k - 2) % 20;
        if (p < 8) begin
`ifdef SEG_LZB_EN
            if (t == 4'd0) return {p == 0, 2'b11, 8'hFF};
`endif
            return {p == 0, 2'b01, seg_of(t)};
        end
        if (p >= 10 && p < 18) return {1'b0, 2'b10, seg_of(o)};
        return {1'b0, 2'b11, 8'hFF};
    endfunction

    task automatic start(input logic [3:0] t, input logic [3:0] o);
        @(negedge CLK);
        RST = 1'b0;
        bus.Ten_Data = t;
        bus.One_Data = o;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset;
        logic [10:0] obs;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
        n_cmp++;
        if (obs !== {1'b0, 2'b11, 8'hFF}) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", obs, {1'b0, 2'b11, 8'hFF});
        end
    endtask

    task automatic test_basic_frame;
        logic [10:0] obs;
        logic [10:0] exp;
        start(4'd4, 4'd2);
        for (int k = 1; k <= 42; k++) begin
            @(negedge CLK);
            obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
            exp = exp_vec(k, 4'd4, 4'd2);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL basic k=%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_mid_change;
        logic [10:0] obs;
        logic [10:0] exp;
        start(4'd4, 4'd2);
        for (int k = 1; k <= 42; k++) begin
            @(negedge CLK);
            obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
            exp = (k < 22) ? exp_vec(k, 4'd4, 4'd2) : exp_vec(k, 4'd7, 4'd3);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL midchg k=%0d: got %h want %h", k, obs, exp);
            end
            if (k == 5) begin
                bus.Ten_Data = 4'd7;
                bus.One_Data = 4'd3;
            end
        end
    endtask

    task automatic test_invalid;
        logic [10:0] obs;
        logic [10:0] exp;
        start(4'd12, 4'd15);
        for (int k = 1; k <= 22; k++) begin
            @(negedge CLK);
            obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
            exp = exp_vec(k, 4'd12, 4'd15);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL invalid k=%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_zero_tens;
        logic [10:0] obs;
        logic [10:0] exp;
        start(4'd0, 4'd5);
        for (int k = 1; k <= 22; k++) begin
            @(negedge CLK);
            obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
            exp = exp_vec(k, 4'd0, 4'd5);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL zeroten k=%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] obs;
        logic [10:0] exp;
        start(4'd4, 4'd2);
        for (int k = 1; k <= 16; k++) @(negedge CLK);
        n_cmp++;
        if (bus.Scan_Sig !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_pre: got %b want 10", bus.Scan_Sig);
        end
        RST = 1'b0;
        #1;
        obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
        n_cmp++;
        if (obs !== {1'b0, 2'b11, 8'hFF}) begin
            n_bad++;
            $display("FAIL rstmid_async: got %h want %h", obs, {1'b0, 2'b11, 8'hFF});
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge CLK);
            obs = {bus.Frame_Tick, bus.Scan_Sig, bus.SMG_Data};
            exp = exp_vec(k, 4'd4, 4'd2);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rstmid k=%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0] prev_en;
        int         gap_run;
        int         last_tick;
        int         n_tick;
        prev_en   = 2'b11;
        gap_run   = 0;
        last_tick = -1;
        n_tick    = 0;
        start(4'($urandom_range(15)), 4'($urandom_range(15)));
        for (int k = 1; k <= 1000; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (bus.Scan_Sig === 2'b00) begin
                n_bad++;
                $display("FAIL rand_both k=%0d: got 00 want not 00", k);
            end
            if (bus.Scan_Sig === 2'b11) begin
                gap_run++;
            end else begin
                if (prev_en != 2'b11 && bus.Scan_Sig !== prev_en) begin
                    n_cmp++;
                    if (gap_run < 2) begin
                        n_bad++;
                        $display("FAIL rand_gap k=%0d: got %0d want >=2", k, gap_run);
                    end
                end
                prev_en = bus.Scan_Sig;
                gap_run = 0;
            end
            if (bus.Frame_Tick === 1'b1) begin
                n_tick++;
                if (last_tick >= 0) begin
                    n_cmp++;
                    if (k - last_tick != 20) begin
                        n_bad++;
                        $display("FAIL rand_tick k=%0d: got %0d want 20", k, k - last_tick);
                    end
                end
                last_tick = k;
            end
            bus.Ten_Data = 4'($urandom_range(15));
            bus.One_Data = 4'($urandom_range(15));
        end
        n_cmp++;
        if (n_tick != 50) begin
            n_bad++;
            $display("FAIL rand_ntick: got %0d want 50", n_tick);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        bus.Ten_Data = 4'd0;
        bus.One_Data = 4'd0;
        test_reset;
        test_basic_frame;
        test_mid_change;
        test_invalid;
        test_zero_tens;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
